issue_queue: RTL and testbench

ISSUE_QUEUE -- requirements
Module: issue_queue

---
 rtl/issue_queue.sv | 208 ++++++++++++++++++++
 tb/tb_issue_queue.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_queue.sv
// Out-of-order issue queue: tag wakeup, oldest-first select per issue port,
// registered issue outputs, overflow pulse and younger-than flush.
module issue_queue #(
  parameter int QUEUE_SIZE       = 16,
  parameter int NUM_ENQ          = 2,
  parameter int NUM_DEQ          = 2,
  parameter int RESULT_BUS_COUNT = 3,
  parameter int TAG_W            = 6,
  parameter int SQN_W            = 6,
  parameter int FU_W             = 2,
  parameter int PAYLOAD_W        = 96,
  parameter logic [NUM_DEQ*(1<<FU_W)-1:0] PORT_FU_MASK = '1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_ENQ-1:0]                  IN_enqValid,
  input  logic [NUM_ENQ*SQN_W-1:0]            IN_enqSqN,
  input  logic [NUM_ENQ*FU_W-1:0]             IN_enqFu,
  input  logic [NUM_ENQ*TAG_W-1:0]            IN_enqTagA,
  input  logic [NUM_ENQ*TAG_W-1:0]            IN_enqTagB,
  input  logic [NUM_ENQ-1:0]                  IN_enqRdyA,
  input  logic [NUM_ENQ-1:0]                  IN_enqRdyB,
  input  logic [NUM_ENQ*PAYLOAD_W-1:0]        IN_enqPayload,
  input  logic [RESULT_BUS_COUNT-1:0]         IN_resultValid,
  input  logic [RESULT_BUS_COUNT*TAG_W-1:0]   IN_resultTag,
  input  logic [NUM_DEQ-1:0]                  IN_stall,
  input  logic                                IN_invalidate,
  input  logic [SQN_W-1:0]                    IN_invalidateSqN,
  output logic [NUM_DEQ-1:0]                  OUT_valid,
  output logic [NUM_DEQ*SQN_W-1:0]            OUT_sqN,
  output logic [NUM_DEQ*FU_W-1:0]             OUT_fu,
  output logic [NUM_DEQ*PAYLOAD_W-1:0]        OUT_payload,
  output logic [$clog2(QUEUE_SIZE+1)-1:0]     OUT_free,
  output logic                                OUT_overflow
);

  localparam int IDX_W  = $clog2(QUEUE_SIZE);
  localparam int FREE_W = $clog2(QUEUE_SIZE+1);
  localparam int NFU    = 1 << FU_W;

  logic [QUEUE_SIZE-1:0] r_valid;
  logic [SQN_W-1:0]      r_sqN   [QUEUE_SIZE];
  logic [FU_W-1:0]       r_fu    [QUEUE_SIZE];
  logic [TAG_W-1:0]      r_tagA  [QUEUE_SIZE];
  logic [TAG_W-1:0]      r_tagB  [QUEUE_SIZE];
  logic [QUEUE_SIZE-1:0] r_rdyA;
  logic [QUEUE_SIZE-1:0] r_rdyB;
  logic [PAYLOAD_W-1:0]  r_payload [QUEUE_SIZE];

  logic [QUEUE_SIZE-1:0] w_wokenA;
  logic [QUEUE_SIZE-1:0] w_wokenB;
  logic [QUEUE_SIZE-1:0] w_taken;
  logic [NUM_DEQ-1:0]    w_sel;
  logic [NUM_DEQ-1:0]    w_issue;
  logic [IDX_W-1:0]      w_selIdx [NUM_DEQ];
  logic [NUM_ENQ-1:0]    w_enqFire;
  logic [IDX_W-1:0]      w_enqIdx [NUM_ENQ];
  logic [NUM_ENQ-1:0]    w_enqRdyA;
  logic [NUM_ENQ-1:0]    w_enqRdyB;
  logic                  w_ovf;
  logic [QUEUE_SIZE-1:0] w_validNext;
  logic [FREE_W-1:0]     w_freeNext;

  function automatic logic f_match(input logic [TAG_W-1:0] tag);
    f_match = 1'b0;
    for (int k = 0; k < RESULT_BUS_COUNT; k++)
      if (IN_resultValid[k] && IN_resultTag[k*TAG_W +: TAG_W] == tag)
        f_match = 1'b1;
  endfunction

  function automatic logic f_older(input logic [SQN_W-1:0] a,
                                   input logic [SQN_W-1:0] b);
    logic [SQN_W-1:0] d;
    d = a - b;
    f_older = d[SQN_W-1];
  endfunction

  function automatic logic f_younger(input logic [SQN_W-1:0] a,
                                     input logic [SQN_W-1:0] b);
    logic [SQN_W-1:0] d;
    d = a - b;
    f_younger = !d[SQN_W-1] && (d != '0);
  endfunction

  always_comb begin
    w_wokenA = '0;
    w_wokenB = '0;
    for (int i = 0; i < QUEUE_SIZE; i++) begin
      w_wokenA[i] = r_rdyA[i] | f_match(r_tagA[i]);
      w_wokenB[i] = r_rdyB[i] | f_match(r_tagB[i]);
    end
    w_enqRdyA = '0;
    w_enqRdyB = '0;
    for (int e = 0; e < NUM_ENQ; e++) begin
      w_enqRdyA[e] = IN_enqRdyA[e] | f_match(IN_enqTagA[e*TAG_W +: TAG_W]);
      w_enqRdyB[e] = IN_enqRdyB[e] | f_match(IN_enqTagB[e*TAG_W +: TAG_W]);
    end
  end

  // A stalled port still claims its pick, so higher ports skip it.
  always_comb begin
    w_taken = '0;
    w_sel   = '0;
    w_issue = '0;
    for (int p = 0; p < NUM_DEQ; p++) w_selIdx[p] = '0;
    for (int p = 0; p < NUM_DEQ; p++) begin
      for (int i = 0; i < QUEUE_SIZE; i++) begin
        if (r_valid[i] && w_wokenA[i] && w_wokenB[i] && !w_taken[i] &&
            PORT_FU_MASK[p*NFU + int'(r_fu[i])]) begin
          if (!w_sel[p] || f_older(r_sqN[i], r_sqN[w_selIdx[p]])) begin
            w_sel[p]    = 1'b1;
            w_selIdx[p] = IDX_W'(i);
          end
        end
      end
      if (w_sel[p]) w_taken[w_selIdx[p]] = 1'b1;
      w_issue[p] = w_sel[p] && !IN_stall[p] && !IN_invalidate;
    end
  end

  always_comb begin
    int   n;
    int   k;
    logic hit;
    n = 0;
    k = 0;
    hit = 1'b0;
    w_enqFire = '0;
    for (int e = 0; e < NUM_ENQ; e++) w_enqIdx[e] = '0;
    for (int e = 0; e < NUM_ENQ; e++) begin
      if (IN_enqValid[e] && !IN_invalidate) begin
        k = 0;
        hit = 1'b0;
        for (int i = 0; i < QUEUE_SIZE; i++) begin
          if (!r_valid[i] && !hit) begin
            if (k == n) begin
              hit = 1'b1;
              w_enqIdx[e] = IDX_W'(i);
            end else begin
              k++;
            end
          end
        end
        if (hit) begin
          w_enqFire[e] = 1'b1;
          n++;
        end
      end
    end
    w_ovf = !IN_invalidate && |(IN_enqValid & ~w_enqFire);
  end

  always_comb begin
    w_validNext = r_valid;
    w_freeNext  = FREE_W'(QUEUE_SIZE);
    if (IN_invalidate) begin
      for (int i = 0; i < QUEUE_SIZE; i++)
        if (f_younger(r_sqN[i], IN_invalidateSqN)) w_validNext[i] = 1'b0;
    end else begin
      for (int p = 0; p < NUM_DEQ; p++)
        if (w_issue[p]) w_validNext[w_selIdx[p]] = 1'b0;
      for (int e = 0; e < NUM_ENQ; e++)
        if (w_enqFire[e]) w_validNext[w_enqIdx[e]] = 1'b1;
    end
    for (int i = 0; i < QUEUE_SIZE; i++)
      w_freeNext = w_freeNext - FREE_W'(w_validNext[i]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid      <= '0;
      OUT_valid    <= '0;
      OUT_overflow <= 1'b0;
      OUT_free     <= FREE_W'(QUEUE_SIZE);
    end else begin
      r_valid      <= w_validNext;
      OUT_valid    <= w_issue;
      OUT_overflow <= w_ovf;
      OUT_free     <= w_freeNext;
    end
  end

  always_ff @(posedge clk) begin
    r_rdyA <= w_wokenA;
    r_rdyB <= w_wokenB;
    if (!rst) begin
      for (int e = 0; e < NUM_ENQ; e++) begin
        if (w_enqFire[e]) begin
          r_sqN[w_enqIdx[e]]     <= IN_enqSqN[e*SQN_W +: SQN_W];
          r_fu[w_enqIdx[e]]      <= IN_enqFu[e*FU_W +: FU_W];
          r_tagA[w_enqIdx[e]]    <= IN_enqTagA[e*TAG_W +: TAG_W];
          r_tagB[w_enqIdx[e]]    <= IN_enqTagB[e*TAG_W +: TAG_W];
          r_rdyA[w_enqIdx[e]]    <= w_enqRdyA[e];
          r_rdyB[w_enqIdx[e]]    <= w_enqRdyB[e];
          r_payload[w_enqIdx[e]] <= IN_enqPayload[e*PAYLOAD_W +: PAYLOAD_W];
        end
      end
      for (int p = 0; p < NUM_DEQ; p++) begin
        if (w_issue[p]) begin
          OUT_sqN[p*SQN_W +: SQN_W]         <= r_sqN[w_selIdx[p]];
          OUT_fu[p*FU_W +: FU_W]            <= r_fu[w_selIdx[p]];
          OUT_payload[p*PAYLOAD_W +: PAYLOAD_W] <= r_payload[w_selIdx[p]];
        end
      end
    end
  end

endmodule

// File: tb/tb_issue_queue.sv
// Issue queue bench: queue-of-uops reference model ordered by program
// sequence, directed scenarios with literal expectations, then random traffic.
module tb_issue_queue;

  localparam int Q  = 16;
  localparam int NE = 2;
  localparam int ND = 2;
  localparam int RB = 3;
  localparam logic [7:0] MASK = 8'h7F;

  typedef struct {
    int          seq;
    logic [1:0]  fu;
    logic [5:0]  ta;
    logic [5:0]  tb;
    bit          ra;
    bit          rb;
    logic [95:0] pl;
  } ent_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   IN_enqValid;
  logic [11:0]  IN_enqSqN;
  logic [3:0]   IN_enqFu;
  logic [11:0]  IN_enqTagA;
  logic [11:0]  IN_enqTagB;
  logic [1:0]   IN_enqRdyA;
  logic [1:0]   IN_enqRdyB;
  logic [191:0] IN_enqPayload;
  logic [2:0]   IN_resultValid;
  logic [17:0]  IN_resultTag;
  logic [1:0]   IN_stall;
  logic         IN_invalidate;
  logic [5:0]   IN_invalidateSqN;
  logic [1:0]   OUT_valid;
  logic [11:0]  OUT_sqN;
  logic [3:0]   OUT_fu;
  logic [191:0] OUT_payload;
  logic [4:0]   OUT_free;
  logic         OUT_overflow;

  issue_queue #(.PORT_FU_MASK(MASK)) dut (
    .clk(clk), .rst(rst),
    .IN_enqValid(IN_enqValid), .IN_enqSqN(IN_enqSqN), .IN_enqFu(IN_enqFu),
    .IN_enqTagA(IN_enqTagA), .IN_enqTagB(IN_enqTagB),
    .IN_enqRdyA(IN_enqRdyA), .IN_enqRdyB(IN_enqRdyB),
    .IN_enqPayload(IN_enqPayload),
    .IN_resultValid(IN_resultValid), .IN_resultTag(IN_resultTag),
    .IN_stall(IN_stall), .IN_invalidate(IN_invalidate),
    .IN_invalidateSqN(IN_invalidateSqN),
    .OUT_valid(OUT_valid), .OUT_sqN(OUT_sqN), .OUT_fu(OUT_fu),
    .OUT_payload(OUT_payload), .OUT_free(OUT_free),
    .OUT_overflow(OUT_overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int drv_seq [NE];
  int drv_inv;
  int next_seq;

  ent_t        mq[$];
  logic [1:0]  exp_valid;
  logic [5:0]  exp_sqn [ND];
  logic [1:0]  exp_fu  [ND];
  logic [95:0] exp_pl  [ND];
  bit   [1:0]  known;
  int          exp_free;
  bit          exp_ovf;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit hit(input logic [5:0] t);
    for (int k = 0; k < RB; k++)
      if (IN_resultValid[k] && IN_resultTag[k*6 +: 6] == t) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_step();
    bit   wa [32];
    bit   wb [32];
    bit   tk [32];
    logic [7:0] m;
    int   best;
    int   sz0;
    int   acc;
    ent_t ne;
    m = MASK;
    if (rst) begin
      mq.delete();
      exp_valid = '0;
      exp_free  = Q;
      exp_ovf   = 1'b0;
      known     = '0;
      return;
    end
    for (int i = 0; i < mq.size(); i++) begin
      wa[i] = mq[i].ra || hit(mq[i].ta);
      wb[i] = mq[i].rb || hit(mq[i].tb);
      tk[i] = 1'b0;
    end
    exp_valid = '0;
    exp_ovf   = 1'b0;
    if (IN_invalidate) begin
      for (int i = 0; i < mq.size(); i++) begin
        mq[i].ra = wa[i];
        mq[i].rb = wb[i];
      end
      for (int i = mq.size() - 1; i >= 0; i--)
        if (mq[i].seq > drv_inv) mq.delete(i);
    end else begin
      sz0 = mq.size();
      for (int p = 0; p < ND; p++) begin
        best = -1;
        for (int i = 0; i < mq.size(); i++)
          if (!tk[i] && wa[i] && wb[i] && m[p*4 + int'(mq[i].fu)] &&
              (best < 0 || mq[i].seq < mq[best].seq)) best = i;
        if (best >= 0) begin
          tk[best] = 1'b1;
          if (!IN_stall[p]) begin
            exp_valid[p] = 1'b1;
            exp_sqn[p]   = 6'(mq[best].seq);
            exp_fu[p]    = mq[best].fu;
            exp_pl[p]    = mq[best].pl;
            known[p]     = 1'b1;
          end else begin
            tk[best] = 1'b1;
          end
        end
      end
      for (int i = 0; i < mq.size(); i++) begin
        mq[i].ra = wa[i];
        mq[i].rb = wb[i];
      end
      for (int i = mq.size() - 1; i >= 0; i--)
        if (tk[i] && exp_valid != '0) begin
          for (int p = 0; p < ND; p++)
            if (exp_valid[p] && exp_sqn[p] == 6'(mq[i].seq) &&
                exp_pl[p] == mq[i].pl) begin
              mq.delete(i);
              break;
            end
        end
      acc = 0;
      for (int e = 0; e < NE; e++) begin
        if (IN_enqValid[e]) begin
          if (acc < Q - sz0) begin
            ne.seq = drv_seq[e];
            ne.fu  = IN_enqFu[e*2 +: 2];
            ne.ta  = IN_enqTagA[e*6 +: 6];
            ne.tb  = IN_enqTagB[e*6 +: 6];
            ne.ra  = IN_enqRdyA[e] || hit(ne.ta);
            ne.rb  = IN_enqRdyB[e] || hit(ne.tb);
            ne.pl  = IN_enqPayload[e*96 +: 96];
            mq.push_back(ne);
            acc++;
          end else begin
            exp_ovf = 1'b1;
          end
        end
      end
    end
    exp_free = Q - mq.size();
  endtask

  always @(posedge clk) begin
    model_step();
    #1;
    chk("out_valid", 128'(OUT_valid), 128'(exp_valid));
    chk("out_free", 128'(OUT_free), 128'(exp_free));
    chk("out_overflow", 128'(OUT_overflow), 128'(exp_ovf));
    for (int p = 0; p < ND; p++) begin
      if (known[p]) begin
        chk($sformatf("out_sqN[%0d]", p), 128'(OUT_sqN[p*6 +: 6]),
            128'(exp_sqn[p]));
        chk($sformatf("out_fu[%0d]", p), 128'(OUT_fu[p*2 +: 2]),
            128'(exp_fu[p]));
        chk($sformatf("out_payload[%0d]", p),
            128'(OUT_payload[p*96 +: 96]), 128'(exp_pl[p]));
      end
    end
  end

  task automatic clr();
    IN_enqValid      = '0;
    IN_enqSqN        = '0;
    IN_enqFu         = '0;
    IN_enqTagA       = '0;
    IN_enqTagB       = '0;
    IN_enqRdyA       = '0;
    IN_enqRdyB       = '0;
    IN_enqPayload    = '0;
    IN_resultValid   = '0;
    IN_resultTag     = '0;
    IN_stall         = '0;
    IN_invalidate    = 1'b0;
    IN_invalidateSqN = '0;
  endtask

  task automatic enq(input int e, input int seq, input int fu,
                     input int ta, input bit ra, input int tb, input bit rb);
    IN_enqValid[e]         = 1'b1;
    IN_enqSqN[e*6 +: 6]    = 6'(seq);
    IN_enqFu[e*2 +: 2]     = 2'(fu);
    IN_enqTagA[e*6 +: 6]   = 6'(ta);
    IN_enqTagB[e*6 +: 6]   = 6'(tb);
    IN_enqRdyA[e]          = ra;
    IN_enqRdyB[e]          = rb;
    IN_enqPayload[e*96 +: 96] = {$urandom(), $urandom(), $urandom()};
    drv_seq[e]             = seq;
  endtask

  task automatic bcast(input int k, input int tag);
    IN_resultValid[k]      = 1'b1;
    IN_resultTag[k*6 +: 6] = 6'(tag);
  endtask

  task automatic tick();
    @(negedge clk);
    clr();
  endtask

  task automatic do_reset();
    clr();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  int oldest;

  initial begin
    rst = 1'b1;
    clr();
    drv_inv = 0;
    for (int e = 0; e < NE; e++) drv_seq[e] = 0;
    tick();
    chk("reset_free", 128'(OUT_free), 128'd16);
    chk("reset_valid", 128'(OUT_valid), 128'd0);
    rst = 1'b0;

    // Single ready uop: one-cycle select, registered issue.
    enq(0, 5, 0, 1, 1, 2, 1);
    tick();
    chk("t1_free_after_enq", 128'(OUT_free), 128'd15);
    chk("t1_valid_early", 128'(OUT_valid), 128'd0);
    tick();
    chk("t1_valid", 128'(OUT_valid), 128'b01);
    chk("t1_sqn", 128'(OUT_sqN[5:0]), 128'd5);
    chk("t1_free_after_issue", 128'(OUT_free), 128'd16);
    tick();
    chk("t1_valid_off", 128'(OUT_valid), 128'd0);

    // Waiting operand woken by a later broadcast.
    do_reset();
    enq(0, 3, 0, 9, 0, 0, 1);
    enq(1, 4, 0, 1, 1, 2, 1);
    tick();
    chk("t2_free", 128'(OUT_free), 128'd14);
    tick();
    chk("t2_first_valid", 128'(OUT_valid), 128'b01);
    chk("t2_first_sqn", 128'(OUT_sqN[5:0]), 128'd4);
    bcast(1, 9);
    tick();
    chk("t2_second_valid", 128'(OUT_valid), 128'b01);
    chk("t2_second_sqn", 128'(OUT_sqN[5:0]), 128'd3);
    tick();
    chk("t2_empty", 128'(OUT_free), 128'd16);

    // Full queue overflow, then drain to prove nothing was overwritten.
    do_reset();
    for (int c = 0; c < 8; c++) begin
      enq(0, 2*c, 0, 50, 0, 0, 1);
      enq(1, 2*c+1, 0, 50, 0, 0, 1);
      tick();
    end
    chk("t3_full", 128'(OUT_free), 128'd0);
    chk("t3_no_ovf_yet", 128'(OUT_overflow), 128'd0);
    enq(0, 16, 0, 1, 1, 1, 1);
    enq(1, 17, 0, 1, 1, 1, 1);
    tick();
    chk("t3_ovf", 128'(OUT_overflow), 128'd1);
    chk("t3_full_still", 128'(OUT_free), 128'd0);
    tick();
    chk("t3_ovf_pulse", 128'(OUT_overflow), 128'd0);
    bcast(0, 50);
    tick();
    chk("t3_drain_sqn0", 128'(OUT_sqN[5:0]), 128'd0);
    chk("t3_drain_sqn1", 128'(OUT_sqN[11:6]), 128'd1);
    repeat (9) tick();
    chk("t3_drained", 128'(OUT_free), 128'd16);

    // Sequence-number wrap ordering.
    do_reset();
    enq(0, 62, 0, 20, 0, 0, 1);
    enq(1, 63, 0, 20, 0, 0, 1);
    tick();
    enq(0, 64, 0, 20, 0, 0, 1);
    enq(1, 65, 0, 20, 0, 0, 1);
    tick();
    bcast(2, 20);
    tick();
    chk("t4_valid_a", 128'(OUT_valid), 128'b11);
    chk("t4_p0_a", 128'(OUT_sqN[5:0]), 128'd62);
    chk("t4_p1_a", 128'(OUT_sqN[11:6]), 128'd63);
    tick();
    chk("t4_valid_b", 128'(OUT_valid), 128'b11);
    chk("t4_p0_b", 128'(OUT_sqN[5:0]), 128'd0);
    chk("t4_p1_b", 128'(OUT_sqN[11:6]), 128'd1);

    // Flush of younger entries.
    do_reset();
    enq(0, 10, 0, 30, 0, 0, 1);
    enq(1, 11, 0, 30, 0, 0, 1);
    tick();
    enq(0, 12, 0, 30, 0, 0, 1);
    enq(1, 13, 0, 30, 0, 0, 1);
    tick();
    enq(0, 14, 0, 30, 0, 0, 1);
    tick();
    chk("t5_free_before", 128'(OUT_free), 128'd11);
    IN_invalidate = 1'b1;
    IN_invalidateSqN = 6'd11;
    drv_inv = 11;
    tick();
    chk("t5_free_after", 128'(OUT_free), 128'd14);
    chk("t5_valid_off", 128'(OUT_valid), 128'd0);
    bcast(0, 30);
    tick();
    chk("t5_survivors", 128'(OUT_valid), 128'b11);
    chk("t5_p0", 128'(OUT_sqN[5:0]), 128'd10);
    chk("t5_p1", 128'(OUT_sqN[11:6]), 128'd11);
    tick();
    chk("t5_empty", 128'(OUT_free), 128'd16);

    // Reset while issuing.
    do_reset();
    for (int c = 0; c < 3; c++) begin
      enq(0, 2*c, 0, 40, 0, 0, 1);
      enq(1, 2*c+1, 0, 40, 0, 0, 1);
      tick();
    end
    bcast(0, 40);
    tick();
    chk("t6_issuing", 128'(OUT_valid), 128'b11);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_rst_valid", 128'(OUT_valid), 128'd0);
    chk("t6_rst_free", 128'(OUT_free), 128'd16);
    repeat (3) begin
      tick();
      chk("t6_no_stale_issue", 128'(OUT_valid), 128'd0);
    end

    // Random traffic against the model.
    next_seq = 100;
    repeat (3000) begin
      oldest = next_seq;
      foreach (mq[i]) if (mq[i].seq < oldest) oldest = mq[i].seq;
      for (int e = 0; e < NE; e++) begin
        if ($urandom_range(0, 9) < 6 && next_seq - oldest < 26) begin
          enq(e, next_seq, $urandom_range(0, 3), $urandom_range(0, 15),
              $urandom_range(0, 3) == 0, $urandom_range(0, 15),
              $urandom_range(0, 2) == 0);
          next_seq++;
        end
      end
      for (int k = 0; k < RB; k++)
        if ($urandom_range(0, 1) == 1) bcast(k, $urandom_range(0, 15));
      for (int p = 0; p < ND; p++)
        IN_stall[p] = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 29) == 0) begin
        drv_inv = next_seq - 1 - $urandom_range(0, 8);
        IN_invalidate = 1'b1;
        IN_invalidateSqN = 6'(drv_inv);
        next_seq = drv_inv + 1;
      end
      if ($urandom_range(0, 199) == 0) rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      clr();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
